// File: rtl/ccip_sched_pkg.sv
// Shared constants and helpers for the CCI-P channel schedulers: mdata tag
// layout, index/counter widths and one-hot decode.
package ccip_sched_pkg;

  localparam int MDATA_W     = 16;
  localparam int DEF_TAG_LSB = 12;
  localparam int DEF_MAX_OUT = 32;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cntWidth(input int maxOut);
    return $clog2(maxOut + 1);
  endfunction

  localparam int DEF_CNT_W = cntWidth(DEF_MAX_OUT);

  // Lowest set bit wins; callers only pass one-hot or zero vectors.
  function automatic int onehotToIdx(input logic [31:0] oneHot);
    int idx;
    idx = 0;
    for (int k = 31; k >= 0; k--) begin
      if (oneHot[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or above ptr, wrapping from N-1 back to 0.
module rr_arbiter
  import ccip_sched_pkg::*;
#(
  parameter int N  = 9,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_c0_rr_sched.sv
// Shares the upstream c0 read-request channel among NUM_PORTS requesters,
// tags requests with the port index and routes responses back by that tag.
module ccip_c0_rr_sched
  import ccip_sched_pkg::*;
#(
  parameter int NUM_PORTS = 9,
  parameter int HDR_W     = 74,
  parameter int DATA_W    = 512,
  parameter int MAX_OUT   = DEF_MAX_OUT,
  parameter int TAG_LSB   = DEF_TAG_LSB
) (
  input  logic                       pClk,
  input  logic                       SoftReset,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS*HDR_W-1:0] req_hdr,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic                       tx_almfull,
  output logic                       tx_valid,
  output logic [HDR_W-1:0]           tx_hdr,
  input  logic                       rx_valid,
  input  logic [MDATA_W-1:0]         rx_mdata,
  input  logic [DATA_W-1:0]          rx_data,
  output logic [NUM_PORTS-1:0]       rsp_valid,
  output logic [MDATA_W-1:0]         rsp_mdata,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       err_sticky
);

  localparam int IDX_W = idxWidth(NUM_PORTS);
  localparam int CNT_W = cntWidth(MAX_OUT);
  localparam int TAG_W = MDATA_W - TAG_LSB;
  localparam logic [MDATA_W-1:0] TAG_MASK = {{TAG_W{1'b1}}, {TAG_LSB{1'b0}}};

  logic [CNT_W-1:0]     cnt [NUM_PORTS];
  logic [IDX_W-1:0]     ptr;
  logic [NUM_PORTS-1:0] notFull, cntZero, eligible, grant, rspOneHot;
  logic [IDX_W-1:0]     grantIdx;
  logic [HDR_W-1:0]     taggedHdr;
  logic [TAG_W-1:0]     rspTag;
  logic                 tagOk, underflow;

  assign rspTag    = rx_mdata[MDATA_W-1:TAG_LSB];
  assign tagOk     = {{(32-TAG_W){1'b0}}, rspTag} < NUM_PORTS;
  assign eligible  = req_valid & notFull & {NUM_PORTS{~tx_almfull & ~SoftReset}};
  assign req_ready = grant;
  assign grantIdx  = IDX_W'(onehotToIdx(32'(grant)));
  assign underflow = |(rspOneHot & cntZero);

  rr_arbiter #(.N(NUM_PORTS), .IW(IDX_W)) uArb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gPort
      logic inc, dec;
      assign rspOneHot[gi] = rx_valid & tagOk & (rspTag == TAG_W'(gi));
      assign cntZero[gi]   = (cnt[gi] == '0);
      assign notFull[gi]   = (cnt[gi] != CNT_W'(MAX_OUT));
      assign inc           = grant[gi];
      // A response against an empty counter is flagged, never wrapped.
      assign dec           = rspOneHot[gi] & ~cntZero[gi];

      always_ff @(posedge pClk) begin
        if (SoftReset)        cnt[gi] <= '0;
        else if (inc && !dec) cnt[gi] <= cnt[gi] + 1'b1;
        else if (dec && !inc) cnt[gi] <= cnt[gi] - 1'b1;
      end
    end
  endgenerate

  always_comb begin
    taggedHdr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) taggedHdr = req_hdr[k*HDR_W +: HDR_W];
    end
    taggedHdr[MDATA_W-1:TAG_LSB] = TAG_W'(grantIdx);
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      ptr        <= '0;
      tx_valid   <= 1'b0;
      tx_hdr     <= '0;
      rsp_valid  <= '0;
      rsp_mdata  <= '0;
      rsp_data   <= '0;
      err_sticky <= 1'b0;
    end else begin
      tx_valid  <= |grant;
      rsp_valid <= rspOneHot;
      if (|grant) begin
        tx_hdr <= taggedHdr;
        ptr    <= (grantIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : grantIdx + 1'b1;
      end
      if (rx_valid && tagOk) begin
        rsp_mdata <= rx_mdata & ~TAG_MASK;
        rsp_data  <= rx_data;
      end
      if ((rx_valid && !tagOk) || underflow) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccip_c0_rr_sched.sv
// Directed bench for ccip_c0_rr_sched: ordering, caps, almost-full, response
// steering, error flagging and mid-burst reset.
module tb_ccip_c0_rr_sched;

  localparam int NP = 9;
  localparam int HW = 74;
  localparam int DW = 512;
  localparam int MO = 4;

  logic             pClk = 1'b0;
  logic             SoftReset;
  logic [NP-1:0]    req_valid;
  logic [NP*HW-1:0] req_hdr;
  logic [NP-1:0]    req_ready;
  logic             tx_almfull;
  logic             tx_valid;
  logic [HW-1:0]    tx_hdr;
  logic             rx_valid;
  logic [15:0]      rx_mdata;
  logic [DW-1:0]    rx_data;
  logic [NP-1:0]    rsp_valid;
  logic [15:0]      rsp_mdata;
  logic [DW-1:0]    rsp_data;
  logic             err_sticky;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] patP;

  always #5 pClk = ~pClk;

  ccip_c0_rr_sched #(.NUM_PORTS(NP), .HDR_W(HW), .DATA_W(DW), .MAX_OUT(MO), .TAG_LSB(12)) dut (
    .pClk       (pClk),
    .SoftReset  (SoftReset),
    .req_valid  (req_valid),
    .req_hdr    (req_hdr),
    .req_ready  (req_ready),
    .tx_almfull (tx_almfull),
    .tx_valid   (tx_valid),
    .tx_hdr     (tx_hdr),
    .rx_valid   (rx_valid),
    .rx_mdata   (rx_mdata),
    .rx_data    (rx_data),
    .rsp_valid  (rsp_valid),
    .rsp_mdata  (rsp_mdata),
    .rsp_data   (rsp_data),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic doReset();
    SoftReset  = 1'b1;
    req_valid  = '0;
    rx_valid   = 1'b0;
    tx_almfull = 1'b0;
    tick();
    SoftReset = 1'b0;
  endtask

  // Requester header: original mdata tag bits are 4'hF and must be overwritten.
  function automatic logic [HW-1:0] baseHdr(input int i);
    return {58'(i * 1000 + 7), 4'hF, 12'(i * 16 + 3)};
  endfunction

  function automatic logic [HW-1:0] expHdr(input int i);
    return {58'(i * 1000 + 7), 4'(i), 12'(i * 16 + 3)};
  endfunction

  initial begin
    SoftReset  = 1'b1;
    req_valid  = '1;
    tx_almfull = 1'b0;
    rx_valid   = 1'b0;
    rx_mdata   = '0;
    rx_data    = '0;
    for (int i = 0; i < NP; i++) req_hdr[i*HW +: HW] = baseHdr(i);
    patP = {16{32'hC0DE_0000}} ^ DW'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // 1: reset state, then in-order grants with tag insertion
    tick();
    tick();
    chk("rst_ready", DW'(req_ready), DW'(0));
    chk("rst_txv", DW'(tx_valid), DW'(0));
    chk("rst_txhdr", DW'(tx_hdr), DW'(0));
    chk("rst_rspv", DW'(rsp_valid), DW'(0));
    chk("rst_rspm", DW'(rsp_mdata), DW'(0));
    chk("rst_rspd", rsp_data, DW'(0));
    chk("rst_err", DW'(err_sticky), DW'(0));
    chk("rst_ptr", DW'(dut.ptr), DW'(0));
    SoftReset = 1'b0;
    #1;
    chk("t1_txv_pre", DW'(tx_valid), DW'(0));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_ready%0d", k), DW'(req_ready), DW'(1 << (k % NP)));
      tick();
      chk($sformatf("t1_txv%0d", k), DW'(tx_valid), DW'(1));
      chk($sformatf("t1_hdr%0d", k), DW'(tx_hdr), DW'(expHdr(k % NP)));
      $display("t1 grant %0d tx_hdr=%0h", k % NP, tx_hdr);
    end

    // 2: outstanding cap on port 3
    doReset();
    req_valid = NP'(1 << 3);
    for (int n = 0; n < MO; n++) begin
      #1;
      chk("t2_ready", DW'(req_ready), DW'(1 << 3));
      tick();
      chk("t2_txv", DW'(tx_valid), DW'(1));
    end
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("t2_capped", DW'(req_ready), DW'(0));
      tick();
      chk("t2_txv_idle", DW'(tx_valid), DW'(0));
    end
    chk("t2_cnt_full", DW'(dut.cnt[3]), DW'(MO));
    rx_valid = 1'b1;
    rx_mdata = 16'h3055;
    rx_data  = patP;
    #1;
    chk("t2_still_capped", DW'(req_ready), DW'(0));
    tick();
    rx_valid = 1'b0;
    chk("t2_rspv", DW'(rsp_valid), DW'(1 << 3));
    chk("t2_rspm", DW'(rsp_mdata), DW'(16'h0055));
    #1;
    chk("t2_regrant", DW'(req_ready), DW'(1 << 3));
    tick();
    chk("t2_regrant_hdr", DW'(tx_hdr), DW'(expHdr(3)));
    #1;
    chk("t2_capped_again", DW'(req_ready), DW'(0));
    tick();
    chk("t2_txv_end", DW'(tx_valid), DW'(0));
    $display("t2 cap done cnt3=%0d", dut.cnt[3]);

    // 3: almost-full gating
    doReset();
    req_valid = NP'(1 << 8);
    #1;
    chk("t3_ready8", DW'(req_ready), DW'(1 << 8));
    tick();
    chk("t3_txv_beat", DW'(tx_valid), DW'(1));
    tx_almfull = 1'b1;
    req_valid  = NP'((1 << 0) | (1 << 5));
    #1;
    chk("t3_af_ready", DW'(req_ready), DW'(0));
    tick();
    chk("t3_af_txv", DW'(tx_valid), DW'(0));
    chk("t3_af_hold", DW'(tx_hdr), DW'(expHdr(8)));
    tick();
    chk("t3_af_txv2", DW'(tx_valid), DW'(0));
    tx_almfull = 1'b0;
    #1;
    chk("t3_ready0", DW'(req_ready), DW'(1 << 0));
    tick();
    chk("t3_hdr0", DW'(tx_hdr), DW'(expHdr(0)));
    #1;
    chk("t3_ready5", DW'(req_ready), DW'(1 << 5));
    tick();
    chk("t3_hdr5", DW'(tx_hdr), DW'(expHdr(5)));
    req_valid = '0;
    $display("t3 almfull done");

    // 4: response steering to port 5
    rx_valid = 1'b1;
    rx_mdata = 16'h5ABC;
    rx_data  = patP;
    tick();
    rx_valid = 1'b0;
    chk("t4_rspv", DW'(rsp_valid), DW'(1 << 5));
    chk("t4_rspm", DW'(rsp_mdata), DW'(16'h0ABC));
    chk("t4_rspd", rsp_data, patP);
    chk("t4_cnt5", DW'(dut.cnt[5]), DW'(0));
    chk("t4_err", DW'(err_sticky), DW'(0));
    tick();
    chk("t4_rspv_off", DW'(rsp_valid), DW'(0));
    $display("t4 response delivered");

    // 5: bad tag, then underflow on an idle port
    rx_valid = 1'b1;
    rx_mdata = 16'hC123;
    tick();
    rx_valid = 1'b0;
    chk("t5_drop", DW'(rsp_valid), DW'(0));
    chk("t5_err_tag", DW'(err_sticky), DW'(1));
    tick();
    chk("t5_err_sticky", DW'(err_sticky), DW'(1));
    doReset();
    chk("t5_err_clr", DW'(err_sticky), DW'(0));
    rx_valid = 1'b1;
    rx_mdata = 16'h2001;
    tick();
    rx_valid = 1'b0;
    chk("t5_uf_rspv", DW'(rsp_valid), DW'(1 << 2));
    chk("t5_uf_rspm", DW'(rsp_mdata), DW'(16'h0001));
    chk("t5_err_uf", DW'(err_sticky), DW'(1));
    chk("t5_cnt2", DW'(dut.cnt[2]), DW'(0));
    $display("t5 error cases done");

    // 6: simultaneous grant/response, then reset mid-burst
    doReset();
    req_valid = NP'(1 << 7);
    #1;
    chk("t6_ready7", DW'(req_ready), DW'(1 << 7));
    tick();
    chk("t6_cnt7a", DW'(dut.cnt[7]), DW'(1));
    rx_valid = 1'b1;
    rx_mdata = 16'h7000;
    #1;
    chk("t6_ready7b", DW'(req_ready), DW'(1 << 7));
    tick();
    rx_valid = 1'b0;
    chk("t6_cnt7b", DW'(dut.cnt[7]), DW'(1));
    chk("t6_rspv7", DW'(rsp_valid), DW'(1 << 7));
    req_valid = '1;
    rx_valid  = 1'b1;
    rx_mdata  = 16'hF000;
    tick();
    rx_valid = 1'b0;
    chk("t6_err_set", DW'(err_sticky), DW'(1));
    tick();
    chk("t6_burst_txv", DW'(tx_valid), DW'(1));
    SoftReset = 1'b1;
    #1;
    chk("t6_rst_ready", DW'(req_ready), DW'(0));
    tick();
    chk("t6_rst_txv", DW'(tx_valid), DW'(0));
    chk("t6_rst_err", DW'(err_sticky), DW'(0));
    chk("t6_rst_ptr", DW'(dut.ptr), DW'(0));
    chk("t6_rst_rspv", DW'(rsp_valid), DW'(0));
    for (int i = 0; i < NP; i++) chk($sformatf("t6_rst_cnt%0d", i), DW'(dut.cnt[i]), DW'(0));
    SoftReset = 1'b0;
    req_valid = '0;
    $display("t6 reset mid-burst done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
